// File: rtl/shift_add_mult32_pkg.sv
// Shared constants and state encoding for the iterative shift-and-add multiplier.
package shift_add_mult32_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MUL_CNT_W  = 5;

  // ALU opcode on which the control unit raises START
  localparam logic [5:0] OPC_MUL = 6'h18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/shift_add_mult32_twos_comp_neg.sv
// Parameterised two's-complement negator (~x + 1); purely combinational.
module twos_comp_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] neg_o
);

  assign neg_o = ~x_i + W'(1);

endmodule

// File: rtl/shift_add_mult32.sv
// 32x32->64 shift-and-add multiplier: one bit per cycle, fixed 32-cycle RUN,
// START/READY/DONE handshake, signed handled by magnitude multiply plus final negate.
module shift_add_mult32
  import shift_add_mult32_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W,
  parameter int CNT_W  = MUL_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SIGNED,
  input  logic [DATA_W-1:0] OP_A,
  input  logic [DATA_W-1:0] OP_B,
  output logic              READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  mul_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   mag_a_q, mag_a_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [DATA_W-1:0]   neg_a, neg_b, mag_a_in, mag_b_in;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod_next, prod_neg;

  twos_comp_neg #(.W(DATA_W))   u_neg_a (.x_i(OP_A),      .neg_o(neg_a));
  twos_comp_neg #(.W(DATA_W))   u_neg_b (.x_i(OP_B),      .neg_o(neg_b));
  twos_comp_neg #(.W(2*DATA_W)) u_neg_p (.x_i(prod_next), .neg_o(prod_neg));

  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign mag_a_in = (SIGNED && OP_A[DATA_W-1]) ? neg_a : OP_A;
  assign mag_b_in = (SIGNED && OP_B[DATA_W-1]) ? neg_b : OP_B;

  assign sum       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
  assign prod_next = {sum, acc_lo_q[DATA_W-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mag_a_d  = mag_a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          mag_a_d  = mag_a_in;
          acc_hi_d = '0;
          acc_lo_d = mag_b_in;
          neg_d    = SIGNED & (OP_A[DATA_W-1] ^ OP_B[DATA_W-1]);
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        {acc_hi_d, acc_lo_d} = prod_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d         = '0;
          {hi_d, lo_d}  = neg_q ? prod_neg : prod_next;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mag_a_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mag_a_q  <= mag_a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign READY = (state_q == ST_IDLE);
  assign BUSY  = (state_q == ST_RUN);
  assign DONE  = (state_q == ST_DONE);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
